// File: rtl/dma_guard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_guard_pkg: shared types and end-address helper for the DMA guard. Rev 1.0
// ----------------------------------------------------------------------------
package dma_guard_pkg;

  localparam int GUARD_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } guard_chk_state_e;

  typedef struct packed {
    logic [GUARD_ADDR_W-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic                    is_write;
  } guard_req_t;

  typedef struct packed {
    logic [GUARD_ADDR_W-1:0] base;
    logic [GUARD_ADDR_W-1:0] last;
    logic                    en;
  } guard_win_t;

  // Last byte touched by a burst; the extra MSB flags a wrap past the top of memory.
  function automatic logic [GUARD_ADDR_W:0] req_end(input logic [GUARD_ADDR_W-1:0] addr,
                                                    input logic [7:0]              len,
                                                    input logic [2:0]              size);
    logic [GUARD_ADDR_W:0] bytes;
    bytes = (GUARD_ADDR_W+1)'({1'b0, len} + 9'd1) << size;
    return {1'b0, addr} + bytes - (GUARD_ADDR_W+1)'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_guard_window_table.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_guard_window_table: allowed-window registers with one combinational hit port. Rev 1.0
// ----------------------------------------------------------------------------
module dma_guard_window_table
  import dma_guard_pkg::*;
#(
  parameter int NUM_WINDOWS = 4,
  parameter int IDX_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [GUARD_ADDR_W-1:0] cfg_base,
  input  logic [GUARD_ADDR_W-1:0] cfg_last,
  input  logic                    cfg_en,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic [GUARD_ADDR_W-1:0] req_addr,
  input  logic [GUARD_ADDR_W:0]   req_end_addr,
  output logic                    hit
);

  guard_win_t win [NUM_WINDOWS];
  guard_win_t sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WINDOWS; i++) win[i] <= '0;
    end else if (cfg_we && ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_WINDOWS))) begin
      win[cfg_idx] <= '{base: cfg_base, last: cfg_last, en: cfg_en};
    end
  end

  assign sel = win[rd_idx];

  // base>last can never satisfy both bounds, so such a window never hits.
  assign hit = sel.en && (sel.base <= req_addr) &&
               (req_end_addr[GUARD_ADDR_W-1:0] <= sel.last) && !req_end_addr[GUARD_ADDR_W];

endmodule
`default_nettype wire

// File: rtl/dma_guard_addr_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_guard_addr_checker: AW/AR round-robin arbiter, window-scan FSM, deny stats. Rev 1.0
// ----------------------------------------------------------------------------
module dma_guard_addr_checker
  import dma_guard_pkg::*;
#(
  parameter  int ADDR_WIDTH  = GUARD_ADDR_W,
  parameter  int NUM_WINDOWS = 4,
  parameter  int CNT_WIDTH   = 16,
  localparam int IDX_W       = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [7:0]            wr_req_len,
  input  logic [2:0]            wr_req_size,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [7:0]            rd_req_len,
  input  logic [2:0]            rd_req_size,
  output logic                  chk_valid,
  input  logic                  chk_ready,
  output logic                  chk_is_write,
  output logic                  chk_allow,
  output logic [ADDR_WIDTH-1:0] chk_addr,
  output logic [7:0]            chk_len,
  output logic [2:0]            chk_size,
  input  logic                  guard_enable,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_last,
  input  logic                  cfg_en,
  output logic [CNT_WIDTH-1:0]  deny_count,
  output logic [ADDR_WIDTH-1:0] deny_addr,
  output logic                  deny_irq
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WINDOWS - 1);

  guard_chk_state_e      state;
  guard_req_t            req;
  logic [IDX_W-1:0]      idx;
  logic                  favor_rd;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  win_hit;
  logic [GUARD_ADDR_W:0] end_addr;

  assign grant_wr = (state == IDLE) && wr_req_valid && (!rd_req_valid || !favor_rd);
  assign grant_rd = (state == IDLE) && rd_req_valid && (!wr_req_valid || favor_rd);
  assign wr_req_ready = grant_wr;
  assign rd_req_ready = grant_rd;

  assign end_addr     = req_end(req.addr, req.len, req.size);
  assign chk_is_write = req.is_write;
  assign chk_addr     = req.addr;
  assign chk_len      = req.len;
  assign chk_size     = req.size;

  dma_guard_window_table #(
    .NUM_WINDOWS (NUM_WINDOWS),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk          (ACLK),
    .rst_n        (ARESETN),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_base     (cfg_base),
    .cfg_last     (cfg_last),
    .cfg_en       (cfg_en),
    .rd_idx       (idx),
    .req_addr     (req.addr),
    .req_end_addr (end_addr),
    .hit          (win_hit)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      req        <= '0;
      idx        <= '0;
      favor_rd   <= 1'b0;
      chk_valid  <= 1'b0;
      chk_allow  <= 1'b0;
      deny_count <= '0;
      deny_addr  <= '0;
      deny_irq   <= 1'b0;
    end else begin
      deny_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            favor_rd <= grant_wr;
            idx      <= '0;
            if (grant_wr) req <= '{addr: wr_req_addr, len: wr_req_len, size: wr_req_size, is_write: 1'b1};
            else          req <= '{addr: rd_req_addr, len: rd_req_len, size: rd_req_size, is_write: 1'b0};
            if (guard_enable) begin
              state <= SCAN;
            end else begin
              state     <= RESP;
              chk_valid <= 1'b1;
              chk_allow <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (win_hit) begin
            state     <= RESP;
            chk_valid <= 1'b1;
            chk_allow <= 1'b1;
          end else if (idx == LAST_IDX) begin
            state     <= RESP;
            chk_valid <= 1'b1;
            chk_allow <= 1'b0;
            deny_irq  <= 1'b1;
            deny_addr <= req.addr;
            if (deny_count != '1) deny_count <= deny_count + 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESP: begin
          if (chk_ready) begin
            chk_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_guard_addr_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dma_guard_addr_checker: directed vectors for the guard address checker. Rev 1.0
// ----------------------------------------------------------------------------
module tb_dma_guard_addr_checker;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
  logic [31:0] wr_req_addr, rd_req_addr;
  logic [7:0]  wr_req_len, rd_req_len;
  logic [2:0]  wr_req_size, rd_req_size;
  logic        chk_valid, chk_ready, chk_is_write, chk_allow;
  logic [31:0] chk_addr;
  logic [7:0]  chk_len;
  logic [2:0]  chk_size;
  logic        guard_enable, cfg_we, cfg_en;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_base, cfg_last;
  logic [15:0] deny_count;
  logic [31:0] deny_addr;
  logic        deny_irq;

  // Second instance: one window, 4-bit counter, used for the saturation check.
  logic        s_wr_ready, s_rd_valid, s_rd_ready, s_chk_valid, s_chk_ready;
  logic        s_chk_is_write, s_chk_allow, s_deny_irq;
  logic [31:0] s_chk_addr, s_deny_addr;
  logic [7:0]  s_chk_len;
  logic [2:0]  s_chk_size;
  logic [3:0]  s_deny_count;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  dma_guard_addr_checker #(.ADDR_WIDTH(32), .NUM_WINDOWS(4), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_req_size(wr_req_size),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_size(rd_req_size),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_is_write(chk_is_write),
    .chk_allow(chk_allow), .chk_addr(chk_addr), .chk_len(chk_len), .chk_size(chk_size),
    .guard_enable(guard_enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
    .cfg_last(cfg_last), .cfg_en(cfg_en),
    .deny_count(deny_count), .deny_addr(deny_addr), .deny_irq(deny_irq)
  );

  dma_guard_addr_checker #(.ADDR_WIDTH(32), .NUM_WINDOWS(1), .CNT_WIDTH(4)) dut_sat (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_req_valid(1'b0), .wr_req_ready(s_wr_ready), .wr_req_addr(32'h0),
    .wr_req_len(8'h0), .wr_req_size(3'h0),
    .rd_req_valid(s_rd_valid), .rd_req_ready(s_rd_ready), .rd_req_addr(32'h0000_4000),
    .rd_req_len(8'h0), .rd_req_size(3'h0),
    .chk_valid(s_chk_valid), .chk_ready(s_chk_ready), .chk_is_write(s_chk_is_write),
    .chk_allow(s_chk_allow), .chk_addr(s_chk_addr), .chk_len(s_chk_len), .chk_size(s_chk_size),
    .guard_enable(1'b1), .cfg_we(1'b0), .cfg_idx(1'b0), .cfg_base(32'h0),
    .cfg_last(32'h0), .cfg_en(1'b0),
    .deny_count(s_deny_count), .deny_addr(s_deny_addr), .deny_irq(s_deny_irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_win(input logic [1:0] idx, input logic [31:0] base, input logic [31:0] last,
                         input logic en);
    @(negedge ACLK);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_last = last; cfg_en = en;
    @(negedge ACLK);
    cfg_we = 1'b0;
  endtask

  // Issues one request and returns at the first negedge where chk_valid is seen.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, output int lat);
    int n;
    logic granted;
    @(negedge ACLK);
    if (wr) begin
      wr_req_valid = 1'b1; wr_req_addr = addr; wr_req_len = len; wr_req_size = size;
    end else begin
      rd_req_valid = 1'b1; rd_req_addr = addr; rd_req_len = len; rd_req_size = size;
    end
    #1;
    n = 0;
    granted = wr ? wr_req_ready : rd_req_ready;
    while (!granted && n < 20) begin
      @(negedge ACLK); #1;
      n++;
      granted = wr ? wr_req_ready : rd_req_ready;
    end
    check_eq({tag, "_grant"}, granted, 1);
    @(posedge ACLK); #1;
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge ACLK);
      lat++;
    end while (!chk_valid && lat < 40);
  endtask

  task automatic consume();
    chk_ready = 1'b1;
    @(posedge ACLK); #1;
    chk_ready = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic exp_allow, input int exp_lat);
    int lat;
    do_req(tag, wr, addr, len, size, lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_allow"}, chk_allow, exp_allow);
    check_eq({tag, "_is_write"}, chk_is_write, wr);
    check_eq({tag, "_addr"}, chk_addr, addr);
    check_eq({tag, "_lensize"}, {chk_len, chk_size}, {len, size});
    check_eq({tag, "_irq"}, deny_irq, !exp_allow);
    consume();
    @(negedge ACLK);
    check_eq({tag, "_irq_clr"}, deny_irq, 0);
    check_eq({tag, "_valid_clr"}, chk_valid, 0);
  endtask

  initial begin
    int lat, nv, cyc, both, pulses, nready;
    logic stable;
    ARESETN = 1'b0;
    wr_req_valid = 0; wr_req_addr = 0; wr_req_len = 0; wr_req_size = 0;
    rd_req_valid = 0; rd_req_addr = 0; rd_req_len = 0; rd_req_size = 0;
    chk_ready = 0; guard_enable = 1; cfg_we = 0; cfg_idx = 0; cfg_base = 0; cfg_last = 0;
    cfg_en = 0; s_rd_valid = 0; s_chk_ready = 0;
    repeat (3) @(negedge ACLK);
    check_eq("rst_chk_valid", chk_valid, 0);
    check_eq("rst_outputs", {chk_allow, chk_is_write, chk_addr, deny_irq}, 0);
    check_eq("rst_deny_count", deny_count, 0);
    check_eq("rst_ready", {wr_req_ready, rd_req_ready}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    set_win(2'd0, 32'h0000_1000, 32'h0000_1FFF, 1'b1);
    run_req("t1_wr_hit", 1'b1, 32'h0000_1000, 8'd7, 3'd2, 1'b1, 2);
    check_eq("t1_deny_count", deny_count, 0);
    run_req("t2_rd_deny", 1'b0, 32'h0000_1FF0, 8'd7, 3'd2, 1'b0, 5);
    check_eq("t2_deny_addr", deny_addr, 32'h0000_1FF0);
    check_eq("t2_deny_count", deny_count, 1);

    // Both sides always valid: grants must alternate starting with write.
    @(negedge ACLK);
    wr_req_addr = 32'h0000_1000; wr_req_len = 0; wr_req_size = 0;
    rd_req_addr = 32'h0000_1800; rd_req_len = 0; rd_req_size = 0;
    wr_req_valid = 1; rd_req_valid = 1; chk_ready = 1;
    nv = 0; cyc = 0; both = 0;
    while (nv < 8 && cyc < 200) begin
      @(negedge ACLK);
      cyc++;
      if (wr_req_ready && rd_req_ready) both++;
      if (chk_valid) begin
        check_eq("t3_rr_order", chk_is_write, (nv % 2 == 0));
        nv++;
      end
    end
    wr_req_valid = 0; rd_req_valid = 0;
    @(posedge ACLK); #1;
    chk_ready = 0;
    check_eq("t3_verdicts", nv, 8);
    check_eq("t3_dual_grant", both, 0);

    set_win(2'd3, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b1);
    run_req("t4_wrap", 1'b0, 32'hFFFF_FFF0, 8'd7, 3'd2, 1'b0, 5);
    check_eq("t4_deny_addr", deny_addr, 32'hFFFF_FFF0);
    run_req("t4_top", 1'b0, 32'hFFFF_FFE0, 8'd7, 3'd2, 1'b1, 5);

    guard_enable = 1'b0;
    run_req("t5_bypass", 1'b1, 32'hDEAD_0000, 8'd0, 3'd0, 1'b1, 1);
    guard_enable = 1'b1;
    check_eq("t5_deny_count", deny_count, 2);

    // Saturation on the 4-bit counter instance.
    @(negedge ACLK);
    s_rd_valid = 1; s_chk_ready = 1;
    pulses = 0; cyc = 0;
    while (pulses < 20 && cyc < 300) begin
      @(negedge ACLK);
      cyc++;
      if (s_deny_irq) begin
        pulses++;
        if (pulses == 14) check_eq("t5_sat_14", s_deny_count, 4'hE);
        if (pulses == 15) check_eq("t5_sat_15", s_deny_count, 4'hF);
      end
    end
    s_rd_valid = 0;
    check_eq("t5_sat_pulses", pulses, 20);
    check_eq("t5_sat_final", s_deny_count, 4'hF);

    // Back-pressure: verdict held while chk_ready stays low.
    do_req("t6_stall", 1'b0, 32'h0000_5000, 8'd3, 3'd1, lat);
    check_eq("t6_stall_lat", lat, 5);
    wr_req_valid = 1; rd_req_valid = 1;
    stable = 1; nready = 0;
    repeat (10) begin
      @(negedge ACLK); #1;
      if (!chk_valid || chk_addr !== 32'h0000_5000 || chk_allow !== 1'b0 ||
          chk_len !== 8'd3 || chk_size !== 3'd1) stable = 0;
      if (wr_req_ready || rd_req_ready) nready++;
    end
    check_eq("t6_stall_stable", stable, 1);
    check_eq("t6_stall_ready", nready, 0);
    wr_req_valid = 0; rd_req_valid = 0;
    consume();
    check_eq("t6_deny_count", deny_count, 3);

    // Reset mid-SCAN.
    @(negedge ACLK);
    rd_req_valid = 1; rd_req_addr = 32'h0000_5000; rd_req_len = 0; rd_req_size = 0;
    @(posedge ACLK); #1;
    rd_req_valid = 0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    check_eq("t6_rst_valid", chk_valid, 0);
    check_eq("t6_rst_count", deny_count, 0);
    check_eq("t6_rst_deny_addr", deny_addr, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    run_req("t6_cleared", 1'b1, 32'h0000_1000, 8'd7, 3'd2, 1'b0, 5);
    check_eq("t6_cleared_count", deny_count, 1);

    // Reset mid-RESP must drop chk_valid without a clock edge.
    do_req("t6_resp", 1'b1, 32'h0000_1100, 8'd0, 3'd0, lat);
    check_eq("t6_resp_valid", chk_valid, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    check_eq("t6_async_valid", chk_valid, 0);
    check_eq("t6_async_count", deny_count, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
